// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 slave backed by an on-chip word-addressed memory.
// Write (AW/W/B) and read (AR/R) paths are independent FSMs and run concurrently.
// Ports:
//   ACLK, ARESETn                        clock, asynchronous active-low reset
//   AW*: AWADDR/AWLEN/AWSIZE/AWBURST, AWVALID/AWREADY   write address channel
//   W*:  WDATA/WSTRB/WLAST, WVALID/WREADY               write data channel
//   B*:  BRESP, BVALID/BREADY                           write response channel
//   AR*: ARADDR/ARLEN/ARSIZE/ARBURST, ARVALID/ARREADY   read address channel
//   R*:  RDATA/RRESP/RLAST, RVALID/RREADY               read data channel
// Memory contents are not reset. Errors report SLVERR (2'b10).
module axi4_slave_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int unsigned BYTE_LANES = DATA_WIDTH / 8;
    localparam int unsigned OFFS_W     = $clog2(BYTE_LANES);
    localparam int unsigned IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic       {RIdle, RData}        r_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Next beat address for FIXED / INCR / WRAP; illegal WRAP and reserved advance as INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] res;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   res = addr;
            2'b10: begin
                if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) begin
                    res = (addr & ~mask) | ((addr + step) & mask);
                end else begin
                    res = addr + step;
                end
            end
            default: res = addr + step;
        endcase
        return res;
    endfunction

    // Burst-wide error: oversize beat, reserved burst type or illegal WRAP length.
    function automatic logic burst_err(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (32'(size) > OFFS_W) || (burst == 2'b11) || (burst == 2'b10 && !wrap_ok);
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> OFFS_W) >= ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    // ---------------- write path ----------------
    w_state_e              w_state;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q;
    logic [7:0]            w_beat_q;
    logic                  w_err_q;
    logic                  w_oor, w_last_beat, w_err_now, mem_we;
    logic [IDX_W-1:0]      w_idx;

    always_comb begin
        w_oor       = out_of_range(w_addr_q);
        w_idx       = IDX_W'(w_addr_q >> OFFS_W);
        w_last_beat = (w_beat_q == w_len_q);
        w_err_now   = w_err_q || w_oor || (WLAST != w_last_beat);
        mem_we      = (w_state == WData) && WVALID && WREADY && !w_oor;
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BYTE_LANES); b++) begin
                if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state   <= WIdle;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= 2'b00;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state)
                WIdle: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        AWREADY   <= 1'b0;
                        WREADY    <= 1'b1;
                        w_addr_q  <= AWADDR;
                        w_len_q   <= AWLEN;
                        w_size_q  <= AWSIZE;
                        w_burst_q <= AWBURST;
                        w_beat_q  <= '0;
                        w_err_q   <= burst_err(AWSIZE, AWLEN, AWBURST);
                        w_state   <= WData;
                    end
                end
                WData: begin
                    if (WVALID && WREADY) begin
                        w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                        w_beat_q <= w_beat_q + 8'd1;
                        w_err_q  <= w_err_now;
                        // Burst length comes from AWLEN; WLAST only feeds the error flag.
                        if (w_last_beat) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= w_err_now ? 2'b10 : 2'b00;
                            w_state <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= 2'b00;
                        AWREADY <= 1'b1;
                        w_state <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_e              r_state;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_next_addr, r_load_addr;
    logic [7:0]            r_len_q;
    logic [2:0]            r_size_q;
    logic [1:0]            r_burst_q;
    logic [7:0]            r_beat_q;
    logic                  r_err_q, r_load_err, r_load_oor;
    logic [IDX_W-1:0]      r_load_idx;
    logic [DATA_WIDTH-1:0] r_load_data;
    logic [1:0]            r_load_resp;

    // The beat being loaded: first beat from AR, later beats from the advanced address.
    always_comb begin
        r_next_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
        if (r_state == RIdle) begin
            r_load_addr = ARADDR;
            r_load_err  = burst_err(ARSIZE, ARLEN, ARBURST);
        end else begin
            r_load_addr = r_next_addr;
            r_load_err  = r_err_q;
        end
        r_load_oor  = out_of_range(r_load_addr);
        r_load_idx  = IDX_W'(r_load_addr >> OFFS_W);
        r_load_data = r_load_oor ? '0 : mem[r_load_idx];
        r_load_resp = (r_load_err || r_load_oor) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= RIdle;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RDATA     <= '0;
            RRESP     <= 2'b00;
            RLAST     <= 1'b0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
            r_err_q   <= 1'b0;
        end else begin
            case (r_state)
                RIdle: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        ARREADY   <= 1'b0;
                        RVALID    <= 1'b1;
                        r_addr_q  <= ARADDR;
                        r_len_q   <= ARLEN;
                        r_size_q  <= ARSIZE;
                        r_burst_q <= ARBURST;
                        r_beat_q  <= '0;
                        r_err_q   <= r_load_err;
                        RDATA     <= r_load_data;
                        RRESP     <= r_load_resp;
                        RLAST     <= (ARLEN == 8'd0);
                        r_state   <= RData;
                    end
                end
                RData: begin
                    if (RREADY) begin
                        if (r_beat_q == r_len_q) begin
                            RVALID  <= 1'b0;
                            RDATA   <= '0;
                            RRESP   <= 2'b00;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= RIdle;
                        end else begin
                            r_addr_q <= r_next_addr;
                            r_beat_q <= r_beat_q + 8'd1;
                            RDATA    <= r_load_data;
                            RRESP    <= r_load_resp;
                            RLAST    <= ((r_beat_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Testbench for axi4_slave_mem: table of directed bursts plus hand-written
// sequences for read stall and mid-burst reset.
module tb_axi4_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    axi4_slave_mem #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_DEPTH (1024)
    ) dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .AWADDR (AWADDR),
        .AWLEN  (AWLEN),
        .AWSIZE (AWSIZE),
        .AWBURST(AWBURST),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WLAST  (WLAST),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARLEN  (ARLEN),
        .ARSIZE (ARSIZE),
        .ARBURST(ARBURST),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RLAST  (RLAST),
        .RVALID (RVALID),
        .RREADY (RREADY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit              wr;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic [3:0]      strb;
        int              early;   // beat carrying WLAST, -1 for the correct beat
        logic [3:0][31:0] data;   // write data, or expected read data
        logic [1:0]      bresp;
        logic [3:0][1:0] rresp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [3:0] strb, input int early,
                                input logic [127:0] data, input logic [1:0] bresp,
                                input logic [7:0] rresp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.strb = strb; v.early = early; v.data = data; v.bresp = bresp; v.rresp = rresp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        fails++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b);
        int n = 0;
        AWADDR = a; AWLEN = l; AWSIZE = s; AWBURST = b; AWVALID = 1'b1;
        @(negedge ACLK);
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        if (!AWREADY) timed_out("aw handshake");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
        @(negedge ACLK);
        while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
        if (!WREADY) timed_out("w handshake");
        @(posedge ACLK); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] r);
        int n = 0;
        BREADY = 1'b1;
        @(negedge ACLK);
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        if (!BVALID) timed_out("b handshake");
        r = BRESP;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b);
        int n = 0;
        ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b; ARVALID = 1'b1;
        @(negedge ACLK);
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        if (!ARREADY) timed_out("ar handshake");
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    // Caller holds RREADY high; one beat is sampled and consumed.
    task automatic r_recv(output logic [31:0] d, output logic [1:0] r, output logic l);
        int n = 0;
        @(negedge ACLK);
        while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
        if (!RVALID) timed_out("r handshake");
        d = RDATA; r = RRESP; l = RLAST;
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        rl;

        ARESETn = 1'b0;
        AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // Directed table (data packed with beat 0 in the low word).
        vecs.push_back(mk(1, 32'h10, 3, 2, 1, 4'hF, -1,
                          {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2'b00, 8'h00));
        vecs.push_back(mk(0, 32'h10, 3, 2, 1, 4'h0, -1,
                          {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2'b00, 8'h00));
        vecs.push_back(mk(1, 32'h30, 3, 2, 1, 4'hF, -1,
                          {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 2'b00, 8'h00));
        // WRAP from 0x38: 0x38, 0x3C, 0x30, 0x34
        vecs.push_back(mk(0, 32'h38, 3, 2, 2, 4'h0, -1,
                          {32'hB1, 32'hB0, 32'hB3, 32'hB2}, 2'b00, 8'h00));
        vecs.push_back(mk(1, 32'h40, 0, 2, 1, 4'hF, -1,
                          {96'h0, 32'hFFFF_FFFF}, 2'b00, 8'h00));
        vecs.push_back(mk(1, 32'h40, 0, 2, 1, 4'h5, -1,
                          {96'h0, 32'h1122_3344}, 2'b00, 8'h00));
        vecs.push_back(mk(0, 32'h40, 0, 2, 1, 4'h0, -1,
                          {96'h0, 32'hFF22_FF44}, 2'b00, 8'h00));
        // Last word in range, second beat out of range
        vecs.push_back(mk(1, 32'hFFC, 1, 2, 1, 4'hF, -1,
                          {64'h0, 32'hC1, 32'hC0}, 2'b10, 8'h00));
        vecs.push_back(mk(0, 32'hFFC, 1, 2, 1, 4'h0, -1,
                          {64'h0, 32'h0, 32'hC0}, 2'b00, 8'h08));
        // WLAST on beat 1 of a 4-beat burst
        vecs.push_back(mk(1, 32'h50, 3, 2, 1, 4'hF, 1,
                          {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 2'b10, 8'h00));
        // Oversize beat (8 bytes on a 4-byte bus)
        vecs.push_back(mk(1, 32'h60, 0, 3, 1, 4'hF, -1,
                          {96'h0, 32'hE0E0_E0E0}, 2'b10, 8'h00));
        // Reserved burst type
        vecs.push_back(mk(1, 32'h70, 1, 2, 3, 4'hF, -1,
                          {64'h0, 32'h71, 32'h70}, 2'b10, 8'h00));
        // FIXED read repeats one word
        vecs.push_back(mk(0, 32'h10, 2, 2, 0, 4'h0, -1,
                          {32'h0, 32'hA0, 32'hA0, 32'hA0}, 2'b00, 8'h00));
        // WRAP with illegal length 3 beats: INCR addresses, SLVERR per beat
        vecs.push_back(mk(0, 32'h10, 2, 2, 2, 4'h0, -1,
                          {32'h0, 32'hA2, 32'hA1, 32'hA0}, 2'b00, 8'h2A));

        // Reset state
        repeat (3) @(negedge ACLK);
        chk("reset ctrl outputs", 32'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID,
                                      RRESP, RLAST}), 32'h0);
        chk("reset rdata", RDATA, 32'h0);
        ARESETn = 1'b1;
        #1;
        chk("awready before first edge", 32'(AWREADY), 32'h0);
        @(negedge ACLK);
        chk("awready after reset", 32'(AWREADY), 32'h1);
        chk("arready after reset", 32'(ARREADY), 32'h1);
        @(posedge ACLK); #1;

        foreach (vecs[k]) begin
            if (vecs[k].wr) begin
                aw_send(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst);
                for (int i = 0; i <= int'(vecs[k].len); i++) begin
                    w_send(vecs[k].data[i], vecs[k].strb,
                           (vecs[k].early >= 0) ? (i == vecs[k].early)
                                                : (i == int'(vecs[k].len)));
                end
                b_recv(resp);
                chk($sformatf("vec%0d bresp", k), 32'(resp), 32'(vecs[k].bresp));
            end else begin
                ar_send(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst);
                RREADY = 1'b1;
                for (int i = 0; i <= int'(vecs[k].len); i++) begin
                    r_recv(rd, rr, rl);
                    chk($sformatf("vec%0d beat%0d rdata", k, i), rd, vecs[k].data[i]);
                    chk($sformatf("vec%0d beat%0d rresp", k, i), 32'(rr), 32'(vecs[k].rresp[i]));
                    chk($sformatf("vec%0d beat%0d rlast", k, i), 32'(rl),
                        32'(i == int'(vecs[k].len)));
                end
                RREADY = 1'b0;
            end
        end

        // Read stall: beat 1 must hold for 3 cycles with RREADY low.
        ar_send(32'h10, 3, 2, 1);
        RREADY = 1'b1;
        r_recv(rd, rr, rl);
        chk("stall beat0 rdata", rd, 32'hA0);
        RREADY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            chk($sformatf("stall c%0d rvalid", c), 32'(RVALID), 32'h1);
            chk($sformatf("stall c%0d rdata", c), RDATA, 32'hA1);
            chk($sformatf("stall c%0d rlast", c), 32'(RLAST), 32'h0);
        end
        @(posedge ACLK); #1;
        RREADY = 1'b1;
        for (int i = 1; i < 4; i++) begin
            r_recv(rd, rr, rl);
            chk($sformatf("stall beat%0d rdata", i), rd, 32'hA0 + 32'(i));
            chk($sformatf("stall beat%0d rlast", i), 32'(rl), 32'(i == 3));
        end
        RREADY = 1'b0;

        // Reset in the middle of a 4-beat write; two beats already landed.
        aw_send(32'h10, 3, 2, 1);
        w_send(32'hE0, 4'hF, 1'b0);
        w_send(32'hE1, 4'hF, 1'b0);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("midreset ctrl outputs", 32'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID,
                                         RRESP, RLAST}), 32'h0);
        chk("midreset rdata", RDATA, 32'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            chk($sformatf("postreset c%0d bvalid", c), 32'(BVALID), 32'h0);
            chk($sformatf("postreset c%0d awready", c), 32'(AWREADY), 32'h1);
        end
        @(posedge ACLK); #1;
        ar_send(32'h10, 3, 2, 1);
        RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_recv(rd, rr, rl);
            chk($sformatf("after reset beat%0d rdata", i), rd,
                (i < 2) ? 32'hE0 + 32'(i) : 32'hA0 + 32'(i));
            chk($sformatf("after reset beat%0d rresp", i), 32'(rr), 32'h0);
        end
        RREADY = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
